// File: rtl/game_board_controller.sv
// Tic-tac-toe board controller: click-edge detection, move placement, line checking
// and result screens. Define GAME_SCORE_EN to build the saturating win counters.
module game_board_controller #(
    parameter int SCORE_W = 4
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic [8:0]         clickedMatrix,
    input  logic               restart,
    output logic [8:0]         board_x,
    output logic [8:0]         board_o,
    output logic               turnoX,
    output logic               ceStartScreen,
    output logic               ceWinnerXSreen,
    output logic               ceWinnerOSreen,
    output logic               ceTieSreen,
    output logic [SCORE_W-1:0] x_score,
    output logic [SCORE_W-1:0] o_score
);

    // state   | meaning
    // START   | start screen, first click only dismisses it
    // PLAYING | waiting for a valid move from the player in turnoX
    // CHECK   | evaluate the board of the player who just moved
    // WIN_X   | X completed a line, board frozen until restart
    // WIN_O   | O completed a line, board frozen until restart
    // TIE     | board full without a line, frozen until restart
    typedef enum logic [2:0] {START, PLAYING, CHECK, WIN_X, WIN_O, TIE} state_t;

    state_t     state, state_next;
    logic [8:0] prev;
    logic [8:0] click_edge;
    logic [8:0] board_x_next, board_o_next;
    logic [8:0] mover_board;
    logic       turn_next;
    logic       edge_single, move_valid, line_done;

    function automatic logic has_line(input logic [8:0] b);
        return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
               (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    assign click_edge  = clickedMatrix & ~prev;
    assign edge_single = (click_edge != 9'd0) && ((click_edge & (click_edge - 9'd1)) == 9'd0);
    assign move_valid  = edge_single && ((click_edge & (board_x | board_o)) == 9'd0);
    // turnoX is not toggled until CHECK completes, so it still names the mover here
    assign mover_board = turnoX ? board_x : board_o;
    assign line_done   = has_line(mover_board);

    always_comb begin
        state_next   = state;
        board_x_next = board_x;
        board_o_next = board_o;
        turn_next    = turnoX;
        if (restart) begin
            state_next   = START;
            board_x_next = 9'd0;
            board_o_next = 9'd0;
            turn_next    = 1'b1;
        end else begin
            case (state)
                START: begin
                    if (click_edge != 9'd0) state_next = PLAYING;
                end
                PLAYING: begin
                    if (move_valid) begin
                        if (turnoX) board_x_next = board_x | click_edge;
                        else        board_o_next = board_o | click_edge;
                        state_next = CHECK;
                    end
                end
                CHECK: begin
                    if (line_done)                       state_next = turnoX ? WIN_X : WIN_O;
                    else if ((board_x | board_o) == 9'h1FF) state_next = TIE;
                    else begin
                        turn_next  = ~turnoX;
                        state_next = PLAYING;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state          <= START;
            prev           <= 9'd0;
            board_x        <= 9'd0;
            board_o        <= 9'd0;
            turnoX         <= 1'b1;
            ceStartScreen  <= 1'b1;
            ceWinnerXSreen <= 1'b0;
            ceWinnerOSreen <= 1'b0;
            ceTieSreen     <= 1'b0;
        end else begin
            state          <= state_next;
            prev           <= clickedMatrix;
            board_x        <= board_x_next;
            board_o        <= board_o_next;
            turnoX         <= turn_next;
            ceStartScreen  <= (state_next == START);
            ceWinnerXSreen <= (state_next == WIN_X);
            ceWinnerOSreen <= (state_next == WIN_O);
            ceTieSreen     <= (state_next == TIE);
        end
    end

`ifdef GAME_SCORE_EN
    logic               x_win, o_win;
    logic [SCORE_W-1:0] x_cnt, o_cnt;

    assign x_win = (state == CHECK) && !restart && line_done && turnoX;
    assign o_win = (state == CHECK) && !restart && line_done && !turnoX;

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            x_cnt <= '0;
            o_cnt <= '0;
        end else begin
            if (x_win && (x_cnt != '1)) x_cnt <= x_cnt + SCORE_W'(1);
            if (o_win && (o_cnt != '1)) o_cnt <= o_cnt + SCORE_W'(1);
        end
    end

    assign x_score = x_cnt;
    assign o_score = o_cnt;
`else
    assign x_score = '0;
    assign o_score = '0;
`endif

endmodule

// File: doc/game_board_controller.md
GAME_BOARD_CONTROLLER -- requirements
Module: game_board_controller

Interface
REQ-001 Parameter SCORE_W, default 4: width of each win counter.
REQ-002 clk_100MHz  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 clickedMatrix  input  9  per-square click level from the click decoder; bit i = square i, row-major, 0 = top-left; high while mouse button is held over the square.
REQ-005 restart  input  1  level; new game request.
REQ-006 board_x  output  9  squares occupied by X.
REQ-007 board_o  output  9  squares occupied by O.
REQ-008 turnoX  output  1  1 = X to move.
REQ-009 ceStartScreen, ceWinnerXSreen, ceWinnerOSreen, ceTieSreen  output  1 each  screen enables to the VGA painter; at most one high.
REQ-010 x_score, o_score  output  SCORE_W each  games won by X and by O.

Function
REQ-011 Click edge: register clickedMatrix every cycle as prev; edge = clickedMatrix & ~prev.
REQ-012 Valid move: edge has exactly one bit set, and that bit is clear in both board_x and board_o.
- Zero or multiple set bits: ignore.
- Occupied square: ignore.
REQ-013 FSM states: START, PLAYING, CHECK, WIN_X, WIN_O, TIE.
REQ-014 START: ceStartScreen=1.
- Any nonzero edge -> PLAYING.
- That click is consumed and places no mark.
REQ-015 PLAYING, valid move in cycle n:
- Set the square in board_x if turnoX=1, else in board_o, visible at n+1.
- Enter CHECK at n+1.
- Ignore all further edges until back in PLAYING.
REQ-016 CHECK: one cycle; test the 8 lines (3 rows, 3 columns, 2 diagonals) on the board of the player who just moved.
- Line complete -> WIN_X or WIN_O.
- Else board full (board_x|board_o = 9'h1FF) -> TIE.
- Else toggle turnoX -> PLAYING.
- Move at n -> result state at n+2.
REQ-017 A win completed by the 9th mark is reported as a win, not a tie.
REQ-018 WIN_X, WIN_O, TIE:
- Hold the board and assert the matching enable.
- Ignore clicks.
- Leave only via restart or reset.
REQ-019 Score counters:
- Increment x_score on the CHECK->WIN_X transition, o_score on CHECK->WIN_O.
- Saturate at 2^SCORE_W-1.
REQ-020 restart=1 in any state, in cycle n:
- Clear both boards, set turnoX=1, go to START at n+1.
- Scores unchanged.
- restart has priority over any simultaneous click.
REQ-021 ceStartScreen/ceWinnerXSreen/ceWinnerOSreen/ceTieSreen are registered decodes of the state, updating with it.
- All four are 0 in PLAYING and CHECK.
REQ-022 No square is ever set in both board_x and board_o.

Reset
REQ-023 reset=1 at a clock edge:
- state=START, board_x=0, board_o=0, turnoX=1, prev=0.
- ceStartScreen=1, other enables 0.
- x_score=0, o_score=0.
REQ-024 Reset overrides restart and clicks, including mid-CHECK: no score increment occurs.

Configuration
REQ-025 Macro GAME_SCORE_EN.
- Defined: score counters exist as in REQ-019.
- Undefined: no counter flops; x_score and o_score are tied to 0.
- All other behaviour is identical either way.

Verification
REQ-026 Reset, then click sq0 -> START->PLAYING; board_x=0, turnoX=1.
REQ-027 Click sequence 0,3,1,4,2 (X,O,X,O,X) -> board_x=9'h007, board_o=9'h018, ceWinnerXSreen=1 two cycles after the 5th click, x_score=1.
REQ-028 Hold sq4 high for 10 cycles, then click sq4 again -> one X mark only; second click ignored, turnoX stays 0.
REQ-029 clickedMatrix=9'h011 in a single cycle -> no mark placed; state stays PLAYING.
REQ-030 Sequence X0,O1,X2,O4,X3,O5,X7,O6,X8 -> board full with no line; ceTieSreen=1; scores unchanged.
REQ-031 restart asserted together with a click, during CHECK -> START next cycle, boards 0, scores kept. Repeat after 16 X wins (SCORE_W=4) -> x_score=15.
